// File: rtl/lcd_text_writer_if.sv
// Byte-stream handshake between the text source and lcd_text_writer.
// The master offers ASCII bytes and the slave accepts them when ready.
interface lcd_text_writer_if;
   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready;

   modport master (
      output char_valid,
      output char_data,
      input  char_ready
   );

   modport slave (
      input  char_valid,
      input  char_data,
      output char_ready
   );
endinterface

// File: rtl/lcd_text_writer.sv
// Turns an ASCII byte stream into HD44780 nibble transfers.
// Tracks a two-line cursor and re-addresses DDRAM after a wrap or a newline.
module lcd_text_writer #(
   parameter int FREQ = 50000000,
   parameter int COLS = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             initDone,
   lcd_text_writer_if.slave charIf,
   output logic             sendCommand,
   output logic [3:0]       command,
   output logic [20:0]      commandDelay,
   input  logic             commandDone,
   output logic             LCD_RS,
   output logic             cursor_line,
   output logic [5:0]       cursor_col
);
   localparam int          T1US   = FREQ / 1000000;
   localparam logic [20:0] T_HI   = 21'(10 * T1US);
   localparam logic [20:0] T_DATA = 21'(53 * T1US);
   localparam logic [6:0]  COLS_W = 7'(COLS);

   typedef enum logic [2:0] {
      WAIT_INIT, IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO
   } stateType;

   stateType   state;
   logic [7:0] charByte;
   logic       pendAddr;
   logic       lastCol;

   assign lastCol = ({1'b0, cursor_col} + 7'd1) >= COLS_W;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= WAIT_INIT;
         charIf.char_ready <= 1'b0;
         sendCommand       <= 1'b0;
         command           <= 4'h0;
         commandDelay      <= 21'd0;
         LCD_RS            <= 1'b0;
         cursor_line       <= 1'b0;
         cursor_col        <= 6'd0;
         pendAddr          <= 1'b0;
         charByte          <= 8'h00;
      end else begin
         case (state)
            WAIT_INIT: begin
               if (initDone) begin
                  state             <= IDLE;
                  charIf.char_ready <= 1'b1;
                  cursor_line       <= 1'b0;
                  cursor_col        <= 6'd0;
                  pendAddr          <= 1'b0;
               end
            end

            IDLE: begin
               // char_ready low while in IDLE marks the busy cycle after a newline
               if (!charIf.char_ready) begin
                  charIf.char_ready <= 1'b1;
               end else if (charIf.char_valid) begin
                  charIf.char_ready <= 1'b0;
                  charByte          <= charIf.char_data;
                  if (charIf.char_data == 8'h0A) begin
                     cursor_line <= ~cursor_line;
                     cursor_col  <= 6'd0;
                     pendAddr    <= 1'b1;
                  end else begin
                     sendCommand  <= 1'b1;
                     commandDelay <= T_HI;
                     if (pendAddr) begin
                        state   <= ADDR_HI;
                        LCD_RS  <= 1'b0;
                        command <= {1'b1, cursor_line, cursor_col[5:4]};
                     end else begin
                        state   <= DATA_HI;
                        LCD_RS  <= 1'b1;
                        command <= charIf.char_data[7:4];
                     end
                  end
               end
            end

            ADDR_HI: begin
               if (commandDone) begin
                  state        <= ADDR_LO;
                  command      <= cursor_col[3:0];
                  commandDelay <= T_DATA;
               end
            end

            ADDR_LO: begin
               if (commandDone) begin
                  state        <= DATA_HI;
                  pendAddr     <= 1'b0;
                  LCD_RS       <= 1'b1;
                  command      <= charByte[7:4];
                  commandDelay <= T_HI;
               end
            end

            DATA_HI: begin
               if (commandDone) begin
                  state        <= DATA_LO;
                  command      <= charByte[3:0];
                  commandDelay <= T_DATA;
               end
            end

            DATA_LO: begin
               if (commandDone) begin
                  state             <= IDLE;
                  sendCommand       <= 1'b0;
                  charIf.char_ready <= 1'b1;
                  if (lastCol) begin
                     cursor_col  <= 6'd0;
                     cursor_line <= ~cursor_line;
                     pendAddr    <= 1'b1;
                  end else begin
                     cursor_col <= cursor_col + 6'd1;
                  end
               end
            end

            default: state <= WAIT_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomised scoreboard bench for lcd_text_writer with a cursor-level reference
// model and a transfer-stage model that acknowledges each nibble after 5 cycles.
module tb_lcd_text_writer;
   localparam int FREQ   = 50000000;
   localparam int COLS   = 16;
   localparam int T_HI   = (FREQ / 1000000) * 10;
   localparam int T_DATA = (FREQ / 1000000) * 53;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        initDone;
   logic        sendCommand;
   logic [3:0]  command;
   logic [20:0] commandDelay;
   logic        commandDone;
   logic        LCD_RS;
   logic        cursor_line;
   logic [5:0]  cursor_col;
   logic        modelDone = 1'b0;
   logic        spurDone;
   bit          xferEnable;

   int checks = 0;
   int errors = 0;

   // expected nibble record: {RS, nibble, delay}
   logic [25:0] expQ[$];
   int          mLine, mCol;
   bit          mPend;

   lcd_text_writer_if cv();

   assign commandDone = modelDone | spurDone;

   lcd_text_writer #(.FREQ(FREQ), .COLS(COLS)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .initDone(initDone),
      .charIf(cv),
      .sendCommand(sendCommand),
      .command(command),
      .commandDelay(commandDelay),
      .commandDone(commandDone),
      .LCD_RS(LCD_RS),
      .cursor_line(cursor_line),
      .cursor_col(cursor_col)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: what the LCD should receive for one character.
   task automatic modelChar(input logic [7:0] ch);
      logic [7:0] addr;
      if (ch == 8'h0A) begin
         mLine = 1 - mLine;
         mCol  = 0;
         mPend = 1'b1;
      end else begin
         if (mPend) begin
            addr = 8'(8'h80 + mLine * 64 + mCol);
            expQ.push_back({1'b0, addr[7:4], 21'(T_HI)});
            expQ.push_back({1'b0, addr[3:0], 21'(T_DATA)});
            mPend = 1'b0;
         end
         expQ.push_back({1'b1, ch[7:4], 21'(T_HI)});
         expQ.push_back({1'b1, ch[3:0], 21'(T_DATA)});
         mCol++;
         if (mCol == COLS) begin
            mCol  = 0;
            mLine = 1 - mLine;
            mPend = 1'b1;
         end
      end
   endtask

   // Transfer-stage model and scoreboard monitor.
   bit busy = 1'b0;
   int cnt  = 0;
   always @(negedge CLK) begin
      logic [25:0] exp;
      if (!xferEnable || RESET) begin
         busy      = 1'b0;
         modelDone = 1'b0;
         cnt       = 0;
      end else begin
         if (modelDone) begin
            modelDone = 1'b0;
            busy      = 1'b0;
         end
         if (!busy && sendCommand) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_nibble actual=%0h/%0h/%0d required=none",
                        LCD_RS, command, commandDelay);
            end else begin
               exp = expQ.pop_front();
               check("nibble", {6'd0, LCD_RS, command, commandDelay}, {6'd0, exp});
            end
            busy = 1'b1;
            cnt  = 0;
         end else if (busy) begin
            cnt++;
            if (cnt == 5) modelDone = 1'b1;
         end
      end
   end

   task automatic pulseInit();
      @(negedge CLK);
      initDone = 1'b1;
      @(posedge CLK);
      #1;
      initDone = 1'b0;
      check("ready_after_init", cv.char_ready, 1'b1);
      check("line_after_init", cursor_line, 1'b0);
      check("col_after_init", cursor_col, 6'd0);
   endtask

   task automatic sendChar(input logic [7:0] ch);
      int n;
      n = 0;
      @(negedge CLK);
      cv.char_valid = 1'b1;
      cv.char_data  = ch;
      while (!cv.char_ready && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 required=1");
         cv.char_valid = 1'b0;
      end else begin
         modelChar(ch);
         @(posedge CLK);
         #1;
         cv.char_valid = 1'b0;
         cv.char_data  = 8'($urandom);
         check("ready_drop", cv.char_ready, 1'b0);
         check("send_after_accept", sendCommand, (ch != 8'h0A));
         if (ch == 8'h0A) begin
            @(posedge CLK);
            #1;
            check("nl_ready", cv.char_ready, 1'b1);
         end else begin
            n = 0;
            while (!cv.char_ready && n < 500) begin
               @(posedge CLK);
               #1;
               n++;
            end
            check("done_in_time", (n < 500), 1'b1);
            check("send_dropped", sendCommand, 1'b0);
            check("queue_drained", expQ.size(), 0);
         end
         check("cursor_line", cursor_line, mLine[0]);
         check("cursor_col", cursor_col, mCol[5:0]);
         $display("char %02h -> line %0d col %0d", ch, cursor_line, cursor_col);
      end
   endtask

   initial begin
      repeat (90000) @(posedge CLK);
      checks++;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int bad;
      logic [7:0] ch;
      RESET         = 1'b1;
      initDone      = 1'b0;
      spurDone      = 1'b0;
      xferEnable    = 1'b1;
      cv.char_valid = 1'b0;
      cv.char_data  = 8'h00;
      mLine = 0; mCol = 0; mPend = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_ready", cv.char_ready, 1'b0);
      check("rst_send", sendCommand, 1'b0);
      check("rst_outputs", {command, commandDelay, LCD_RS, cursor_line, cursor_col}, 0);
      @(negedge CLK);
      RESET = 1'b0;

      // No initDone: valid held, nothing may happen; spurious done too.
      cv.char_valid = 1'b1;
      cv.char_data  = 8'h41;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         spurDone = (i == 50);
         @(posedge CLK);
         #1;
         if (cv.char_ready !== 1'b0 || sendCommand !== 1'b0) bad++;
      end
      spurDone = 1'b0;
      cv.char_valid = 1'b0;
      check("wait_init_quiet", bad, 0);

      pulseInit();
      sendChar(8'h41);

      // Spurious commandDone in IDLE changes nothing.
      @(negedge CLK); spurDone = 1'b1;
      @(negedge CLK); spurDone = 1'b0;
      #1;
      check("idle_spur_ready", cv.char_ready, 1'b1);
      check("idle_spur_send", sendCommand, 1'b0);
      check("idle_spur_col", cursor_col, 6'd1);

      // Fill line 0, wrap, then 'B' must be preceded by address 0xC0.
      for (int i = 0; i < 15; i++) sendChar(8'h41);
      check("wrap_line", cursor_line, 1'b1);
      check("wrap_col", cursor_col, 6'd0);
      sendChar(8'h42);
      sendChar(8'h43);
      sendChar(8'h44);
      check("l1c3_col", cursor_col, 6'd3);
      sendChar(8'h0A);
      check("nl_line", cursor_line, 1'b0);
      check("nl_col", cursor_col, 6'd0);
      sendChar(8'h78);

      // Random text with occasional newlines.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0) ch = 8'h0A;
         else ch = 8'($urandom_range(8'h20, 8'h7E));
         sendChar(ch);
      end

      // Reset between the high and low data nibbles.
      if (mPend) sendChar(8'h2E);
      xferEnable = 1'b0;
      @(negedge CLK);
      cv.char_valid = 1'b1;
      cv.char_data  = 8'h5A;
      @(posedge CLK);
      #1;
      cv.char_valid = 1'b0;
      check("man_hi", {sendCommand, LCD_RS, command, commandDelay}, {2'b11, 4'h5, 21'(T_HI)});
      @(negedge CLK); spurDone = 1'b1;
      @(negedge CLK); spurDone = 1'b0;
      #1;
      check("man_lo", {sendCommand, LCD_RS, command, commandDelay}, {2'b11, 4'hA, 21'(T_DATA)});
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_send", sendCommand, 1'b0);
      check("midrst_cursor", {cursor_line, cursor_col}, 7'd0);
      check("midrst_ready", cv.char_ready, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;
      cv.char_valid = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge CLK);
         #1;
         if (cv.char_ready !== 1'b0 || sendCommand !== 1'b0) bad++;
      end
      cv.char_valid = 1'b0;
      check("post_rst_quiet", bad, 0);
      mLine = 0; mCol = 0; mPend = 1'b0;
      expQ.delete();
      xferEnable = 1'b1;
      pulseInit();
      sendChar(8'h5A);
      sendChar(8'h31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
